// File: rtl/aes_enc_arbiter.sv
// Two-requester round-robin arbiter/sequencer for an AES-128 engine, with a one-entry key-owner cache.
// Optional BUSY watchdog enabled by defining AES_ARB_TIMEOUT_EN (limit set by TIMEOUT).
module aes_enc_arbiter #(
    parameter int TIMEOUT = 64
) (
    input  logic         CLK,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [127:0] req0_key,
    input  logic [127:0] req0_din,
    input  logic         req0_kchg,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [127:0] req1_key,
    input  logic [127:0] req1_din,
    input  logic         req1_kchg,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [127:0] rsp_dout,
    output logic         rsp_err,
    output logic [127:0] aes_kin,
    output logic [127:0] aes_din,
    output logic         aes_krdy,
    output logic         aes_drdy,
    output logic         aes_en,
    input  logic [127:0] aes_dout,
    input  logic         aes_kvld,
    input  logic         aes_dvld,
    input  logic         aes_bsy
);
    typedef enum logic [2:0] {IDLE, KEY, KWAIT, DATA, BUSY, DONE} state_t;

    state_t       state_q, state_d;
    logic         last_grant_q, last_grant_d;
    logic         own_q, own_d;
    logic         own_vld_q, own_vld_d;
    logic [127:0] key_q, key_d;
    logic [127:0] din_q, din_d;
    logic         id_q, id_d;
    logic [127:0] dout_q, dout_d;
    logic         err_q, err_d;
    logic         en_q;
    logic         gid, gkchg;

`ifdef AES_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LIM = CW'(TIMEOUT - 1);
    logic [CW-1:0] cnt_q, cnt_d;
`endif

    // Both valid: take the one not served last; otherwise whichever is valid.
    assign gid   = (req0_valid && req1_valid) ? ~last_grant_q : ~req0_valid;
    assign gkchg = gid ? req1_kchg : req0_kchg;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        own_d        = own_q;
        own_vld_d    = own_vld_q;
        key_d        = key_q;
        din_d        = din_q;
        id_d         = id_q;
        dout_d       = dout_q;
        err_d        = err_q;
`ifdef AES_ARB_TIMEOUT_EN
        cnt_d        = cnt_q;
`endif
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        aes_krdy     = 1'b0;
        aes_drdy     = 1'b0;
        case (state_q)
            IDLE: begin
                // en_q keeps grants off until the first edge after reset release
                if (en_q && (req0_valid || req1_valid)) begin
                    req0_ready   = ~gid;
                    req1_ready   = gid;
                    last_grant_d = gid;
                    id_d         = gid;
                    key_d        = gid ? req1_key : req0_key;
                    din_d        = gid ? req1_din : req0_din;
                    err_d        = 1'b0;
                    state_d      = (!own_vld_q || (own_q != gid) || gkchg) ? KEY : DATA;
                end
            end
            KEY: begin
                aes_krdy = 1'b1;
                state_d  = KWAIT;
            end
            KWAIT: begin
                if (aes_kvld) begin
                    own_d     = id_q;
                    own_vld_d = 1'b1;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (!aes_bsy) begin
                    aes_drdy = 1'b1;
                    state_d  = BUSY;
`ifdef AES_ARB_TIMEOUT_EN
                    cnt_d    = '0;
`endif
                end
            end
            BUSY: begin
                if (aes_dvld) begin
                    dout_d  = aes_dout;
                    state_d = DONE;
                end
`ifdef AES_ARB_TIMEOUT_EN
                else if (cnt_q == LIM) begin
                    // Engine state is unknown after a hang, so drop the cached key.
                    dout_d    = '0;
                    err_d     = 1'b1;
                    own_vld_d = 1'b0;
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            DONE: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            own_q        <= 1'b0;
            own_vld_q    <= 1'b0;
            key_q        <= '0;
            din_q        <= '0;
            id_q         <= 1'b0;
            dout_q       <= '0;
            err_q        <= 1'b0;
            en_q         <= 1'b0;
`ifdef AES_ARB_TIMEOUT_EN
            cnt_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            own_q        <= own_d;
            own_vld_q    <= own_vld_d;
            key_q        <= key_d;
            din_q        <= din_d;
            id_q         <= id_d;
            dout_q       <= dout_d;
            err_q        <= err_d;
            en_q         <= 1'b1;
`ifdef AES_ARB_TIMEOUT_EN
            cnt_q        <= cnt_d;
`endif
        end
    end

    assign rsp_valid = (state_q == DONE);
    assign rsp_id    = id_q;
    assign rsp_dout  = dout_q;
`ifdef AES_ARB_TIMEOUT_EN
    assign rsp_err   = err_q;
`else
    assign rsp_err   = 1'b0;
`endif
    assign aes_kin   = key_q;
    assign aes_din   = din_q;
    assign aes_en    = en_q;
endmodule

// File: tb/tb_aes_enc_arbiter.sv
// Bench for aes_enc_arbiter: behavioural AES engine, arbitration/key-cache reference model, random jobs.
// Timeout scenario runs when AES_ARB_TIMEOUT_EN is defined.
module tb_aes_enc_arbiter;
    logic         CLK = 1'b0;
    logic         rst;
    logic         req0_valid, req0_ready, req0_kchg, req1_valid, req1_ready, req1_kchg;
    logic [127:0] req0_key, req0_din, req1_key, req1_din;
    logic         rsp_valid, rsp_ready, rsp_id, rsp_err;
    logic [127:0] rsp_dout, aes_kin, aes_din, aes_dout;
    logic         aes_krdy, aes_drdy, aes_en, aes_kvld, aes_dvld, aes_bsy;

    aes_enc_arbiter #(.TIMEOUT(64)) dut (
        .CLK(CLK), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_key(req0_key),
        .req0_din(req0_din), .req0_kchg(req0_kchg),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_key(req1_key),
        .req1_din(req1_din), .req1_kchg(req1_kchg),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_dout(rsp_dout), .rsp_err(rsp_err),
        .aes_kin(aes_kin), .aes_din(aes_din), .aes_krdy(aes_krdy), .aes_drdy(aes_drdy),
        .aes_en(aes_en), .aes_dout(aes_dout), .aes_kvld(aes_kvld), .aes_dvld(aes_dvld),
        .aes_bsy(aes_bsy)
    );

    always #5 CLK = ~CLK;

    localparam logic [127:0] KA = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PA = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CA = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PB = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CB = 128'h3925841d02dc09fbdc118597196a0b32;

    int checks = 0, errors = 0;
    logic [7:0]   sbox_t [256];
    logic [127:0] pool [3];
    logic [127:0] prev_key [2];
    bit           has_prev [2];
    int           last_g, own;
    bit           own_vld, kill;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // ---------------- AES-128 reference ----------------
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa;
        p = 8'h00; aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= aa;
            aa = xt(aa);
        end
        return p;
    endfunction

    function automatic logic [7:0] rl(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_t[x] = inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3) ^ rl(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes_ref(input logic [127:0] key, input logic [127:0] pt);
        logic [7:0]   s [16], k [16], t [16];
        logic [7:0]   rc, a0, a1, a2, a3;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) begin
            k[i] = key[127-8*i -: 8];
            s[i] = pt[127-8*i -: 8] ^ k[i];
        end
        rc = 8'h01;
        for (int r = 1; r <= 10; r++) begin
            k[0] ^= sbox_t[k[13]] ^ rc;
            k[1] ^= sbox_t[k[14]];
            k[2] ^= sbox_t[k[15]];
            k[3] ^= sbox_t[k[12]];
            for (int i = 4; i < 16; i++) k[i] ^= k[i-4];
            rc = xt(rc);
            for (int i = 0; i < 16; i++) t[i] = sbox_t[s[(i % 4) + 4 * (((i / 4) + (i % 4)) % 4)]];
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                if (r < 10) begin
                    s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end else begin
                    s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
                end
            end
            for (int i = 0; i < 16; i++) s[i] ^= k[i];
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
        return o;
    endfunction

    // ---------------- engine model: kvld 1 cycle after krdy, dvld 11 after drdy ----------------
    logic [127:0] e_key;
    int           e_cnt;
    always @(posedge CLK or posedge rst) begin
        if (rst) begin
            e_key <= '0; aes_kvld <= 1'b0; e_cnt <= 0; aes_dout <= '0;
        end else begin
            aes_kvld <= aes_krdy;
            if (aes_krdy) e_key <= aes_kin;
            if (aes_drdy) begin
                e_cnt    <= 11;
                aes_dout <= aes_ref(e_key, aes_din);
            end else if (e_cnt != 0) begin
                e_cnt <= e_cnt - 1;
            end
        end
    end
    assign aes_bsy  = (e_cnt != 0);
    assign aes_dvld = (e_cnt == 1) && !kill;

    // ---------------- requester side ----------------
    task automatic offer(input int r, input logic [127:0] k, input logic [127:0] d);
        logic kc;
        kc = !has_prev[r] || (prev_key[r] != k);
        prev_key[r] = k; has_prev[r] = 1'b1;
        if (r == 0) begin req0_valid = 1'b1; req0_key = k; req0_din = d; req0_kchg = kc; end
        else        begin req1_valid = 1'b1; req1_key = k; req1_din = d; req1_kchg = kc; end
    endtask

    task automatic model_reset();
        last_g = 1; own = 0; own_vld = 1'b0;
    endtask

    // One full job: predict grant/key-load/latency/result, then follow it cycle by cycle.
    task automatic serve(input int hold, output int g, output int nk, output logic [127:0] dout);
        bit got, kl, done;
        int lat, nd, exp_lat;
        logic [127:0] jk, jd, ed;
        g  = (req0_valid && req1_valid) ? ((last_g == 1) ? 0 : 1) : (req0_valid ? 0 : 1);
        kl = !own_vld || (own != g) || ((g == 1) ? req1_kchg : req0_kchg);
        jk = g ? req1_key : req0_key;
        jd = g ? req1_din : req0_din;
        ed = kill ? '0 : aes_ref(jk, jd);
        exp_lat = kill ? (kl ? 68 : 66) : (kl ? 15 : 13);
        nk = 0; nd = 0; dout = '0; got = 1'b0;
        for (int i = 0; i < 4 && !got; i++) begin
            @(negedge CLK);
            got = req0_ready | req1_ready;
        end
        chk("grant_seen", 128'(got), 128'd1);
        if (!got) return;
        chk("grant_id", {req0_ready, req1_ready}, (g == 1) ? 2'b01 : 2'b10);
        @(posedge CLK); #1;
        if (g == 1) req1_valid = 1'b0; else req0_valid = 1'b0;
        done = 1'b0; lat = 0;
        while (!done && lat < 200) begin
            @(negedge CLK);
            lat++;
            nk += int'(aes_krdy);
            nd += int'(aes_drdy);
            chk("kd_excl", 128'(aes_krdy & aes_drdy), 128'd0);
            chk("rdy_quiet", {req0_ready, req1_ready}, 128'd0);
            done = rsp_valid;
        end
        chk("latency", lat, exp_lat);
        if (!done) return;
        chk("key_loads", nk, kl ? 1 : 0);
        chk("data_loads", nd, 1);
        chk("rsp_id", 128'(rsp_id), g);
        chk("rsp_dout", rsp_dout, ed);
        chk("rsp_err", 128'(rsp_err), 128'(kill));
        dout = rsp_dout;
        for (int h = 0; h < hold; h++) begin
            @(negedge CLK);
            chk("hold_vld", 128'(rsp_valid), 128'd1);
            chk("hold_dout", rsp_dout, ed);
            chk("hold_id", 128'(rsp_id), g);
            chk("hold_quiet", {aes_krdy, aes_drdy, req0_ready, req1_ready}, 128'd0);
        end
        rsp_ready = 1'b1;
        @(posedge CLK); #1;
        rsp_ready = 1'b0;
        chk("rsp_drop", 128'(rsp_valid), 128'd0);
        last_g = g;
        if (kl) begin own = g; own_vld = 1'b1; end
        if (kill) own_vld = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctl"}, {req0_ready, req1_ready, rsp_valid, rsp_id, rsp_err, aes_krdy, aes_drdy, aes_en}, 128'd0);
        chk({tag, "_kin"}, aes_kin, 128'd0);
        chk({tag, "_din"}, aes_din, 128'd0);
        chk({tag, "_dout"}, rsp_dout, 128'd0);
    endtask

    initial begin
        int g, nk;
        bit got;
        logic [127:0] dv;
        rst = 1'b1; kill = 1'b0; rsp_ready = 1'b0;
        req0_valid = 1'b0; req0_key = '0; req0_din = '0; req0_kchg = 1'b0;
        req1_valid = 1'b0; req1_key = '0; req1_din = '0; req1_kchg = 1'b0;
        has_prev[0] = 1'b0; has_prev[1] = 1'b0;
        model_reset();
        build_sbox();
        pool[0] = KA; pool[1] = KB; pool[2] = {$urandom, $urandom, $urandom, $urandom};
        repeat (3) @(posedge CLK);
        #1 chk_all_zero("reset");
        @(negedge CLK) rst = 1'b0;
        @(posedge CLK); #1;
        chk("en_after_rst", 128'(aes_en), 128'd1);
        chk("idle_no_rsp", 128'(rsp_valid), 128'd0);

        // Known-answer job: miss, then same key repeated is a hit.
        offer(0, KA, PA);
        serve(0, g, nk, dv);
        chk("tv_a_ct", dv, CA);
        chk("tv_a_kload", nk, 1);
        offer(0, KA, PA);
        serve(0, g, nk, dv);
        chk("tv_a_hit_ct", dv, CA);
        chk("tv_a_hit_kload", nk, 0);

        // Reset while the engine is busy: everything clears, nothing comes back.
        offer(0, KA, PA);
        got = 1'b0;
        for (int i = 0; i < 4 && !got; i++) begin
            @(negedge CLK);
            got = req0_ready;
        end
        chk("rstjob_grant", 128'(got), 128'd1);
        @(posedge CLK); #1 req0_valid = 1'b0;
        repeat (6) @(posedge CLK);
        #1 rst = 1'b1;
        #1 chk_all_zero("midrst");
        @(negedge CLK) rst = 1'b0;
        model_reset();
        for (int i = 0; i < 16; i++) begin
            @(negedge CLK);
            chk("midrst_no_rsp", 128'(rsp_valid), 128'd0);
        end
        @(posedge CLK); #1;

        // Both requesters contending: order 0,1,0, each switch reloads the key.
        offer(0, KA, PA);
        offer(1, KB, PB);
        serve(0, g, nk, dv);
        chk("rr_first", g, 0);
        chk("rr_first_kload", nk, 1);
        offer(0, KA, PA);
        serve(0, g, nk, dv);
        chk("rr_second", g, 1);
        chk("rr_b_ct", dv, CB);
        chk("rr_second_kload", nk, 1);
        serve(0, g, nk, dv);
        chk("rr_third", g, 0);
        chk("rr_third_kload", nk, 1);

        // Response held for 20 cycles.
        offer(1, KB, PB);
        serve(20, g, nk, dv);
        chk("hold_ct", dv, CB);

`ifdef AES_ARB_TIMEOUT_EN
        kill = 1'b1;
        offer(0, KA, PA);
        serve(0, g, nk, dv);
        kill = 1'b0;
        offer(0, KA, PA);
        serve(0, g, nk, dv);
        chk("after_tmo_kload", nk, 1);
        chk("after_tmo_ct", dv, CA);
`endif

        for (int n = 0; n < 40; n++) begin
            if (!req0_valid && $urandom_range(0, 3) != 0)
                offer(0, pool[$urandom_range(0, 2)], {$urandom, $urandom, $urandom, $urandom});
            if (!req1_valid && $urandom_range(0, 3) != 0)
                offer(1, pool[$urandom_range(0, 2)], {$urandom, $urandom, $urandom, $urandom});
            if (!req0_valid && !req1_valid)
                offer(0, pool[$urandom_range(0, 2)], {$urandom, $urandom, $urandom, $urandom});
            serve($urandom_range(0, 3), g, nk, dv);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
